// File: rtl/alu_rr_arbiter_if.sv
// Request, ALU-drive and response signals of alu_rr_arbiter.
// ALU_ARB_FLAGREG_EN adds the per-requester set-flags bits and the nzcv flag register output.
interface alu_rr_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [2*NREQ-1:0]  req_op;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [31:0]        alu_srcA;
  logic [31:0]        alu_srcB;
  logic [1:0]         alu_ctrl;
  logic [31:0]        alu_result;
  logic [3:0]         alu_flags;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_result;
  logic [3:0]         rsp_flags;
  logic               rsp_err;
`ifdef ALU_ARB_FLAGREG_EN
  logic [NREQ-1:0]    req_s;
  logic [3:0]         nzcv;

  modport master (
    output req_valid, req_op, req_a, req_b, req_s, alu_result, alu_flags, rsp_ready,
    input  req_ready, alu_srcA, alu_srcB, alu_ctrl, rsp_valid, rsp_id, rsp_result,
           rsp_flags, rsp_err, nzcv
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_s, alu_result, alu_flags, rsp_ready,
    output req_ready, alu_srcA, alu_srcB, alu_ctrl, rsp_valid, rsp_id, rsp_result,
           rsp_flags, rsp_err, nzcv
  );
`else
  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, alu_flags, rsp_ready,
    input  req_ready, alu_srcA, alu_srcB, alu_ctrl, rsp_valid, rsp_id, rsp_result,
           rsp_flags, rsp_err
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result, alu_flags, rsp_ready,
    output req_ready, alu_srcA, alu_srcB, alu_ctrl, rsp_valid, rsp_id, rsp_result,
           rsp_flags, rsp_err
  );
`endif
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin sharing of one external combinational ALU, with a one-entry response register.
// ALU_ARB_FLAGREG_EN adds an NZCV register loaded on grants whose set-flags bit is 1.
//
// state | meaning
// EMPTY | response register empty, a request may issue
// FULL  | rsp_valid=1, refill only while rsp_ready drains it
module alu_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input logic              clk,
  input logic              reset,
  alu_rr_arbiter_if.slave  bus
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            grant;
  logic            issue;
  logic [1:0]      sel_op;
  logic            op_ill;
  int              k;

  logic [IDW-1:0]  rsp_id_q;
  logic [31:0]     rsp_result_q;
  logic [3:0]      rsp_flags_q;
  logic            rsp_err_q;

  // First valid requester at or after ptr; falls back to ptr when nothing is valid.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr;
    k       = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!gnt_any && bus.req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(k);
      end
    end
  end

  always_comb begin
    sel_op       = bus.req_op[int'(gnt_idx)*2 +: 2];
    op_ill       = (sel_op == 2'b11);
    bus.alu_srcA = bus.req_a[int'(gnt_idx)*32 +: 32];
    bus.alu_srcB = bus.req_b[int'(gnt_idx)*32 +: 32];
    bus.alu_ctrl = op_ill ? 2'b00 : sel_op;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    issue         = (state == EMPTY) || bus.rsp_ready;
    grant         = issue && gnt_any;
    bus.req_ready = '0;
    if (grant) begin
      bus.req_ready = NREQ'(1) << gnt_idx;
      state_nx      = FULL;
    end else if (state == FULL && bus.rsp_ready) begin
      state_nx      = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (grant) begin
      if (int'(gnt_idx) == NREQ-1) ptr <= '0;
      else                         ptr <= gnt_idx + IDW'(1);
    end
  end

  // Illegal op still completes, but reports zero result/flags with rsp_err set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else if (grant) begin
      rsp_id_q     <= gnt_idx;
      rsp_err_q    <= op_ill;
      rsp_result_q <= op_ill ? 32'd0 : bus.alu_result;
      rsp_flags_q  <= op_ill ? 4'd0  : bus.alu_flags;
    end
  end

  assign bus.rsp_valid  = (state == FULL);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_err    = rsp_err_q;

`ifdef ALU_ARB_FLAGREG_EN
  logic [3:0] nzcv_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      nzcv_q <= 4'd0;
    else if (grant && bus.req_s[gnt_idx] && !op_ill)
      nzcv_q <= bus.alu_flags;
  end

  assign bus.nzcv = nzcv_q;
`endif
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed test of alu_rr_arbiter with a behavioural ALU; expected values are hand-computed.
// The ALU_ARB_FLAGREG_EN section runs only when the macro is defined.
module tb_alu_rr_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 2;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  alu_rr_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: ADD/SUB/MOV-B, flags {N,Z,C,V}, ARM-style carry on SUB.
  logic [32:0] alu_sum;
  logic        alu_v;
  always_comb begin
    alu_sum = 33'd0;
    alu_v   = 1'b0;
    case (bus.alu_ctrl)
      2'b00: begin
        alu_sum = {1'b0, bus.alu_srcA} + {1'b0, bus.alu_srcB};
        alu_v   = (bus.alu_srcA[31] == bus.alu_srcB[31]) && (alu_sum[31] != bus.alu_srcA[31]);
      end
      2'b01: begin
        alu_sum = {1'b0, bus.alu_srcA} + {1'b0, ~bus.alu_srcB} + 33'd1;
        alu_v   = (bus.alu_srcA[31] != bus.alu_srcB[31]) && (alu_sum[31] != bus.alu_srcA[31]);
      end
      default: alu_sum = {1'b0, bus.alu_srcB};
    endcase
    bus.alu_result = alu_sum[31:0];
    bus.alu_flags  = {alu_sum[31], (alu_sum[31:0] == 32'd0), alu_sum[32], alu_v};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    bus.req_valid[idx]        = v;
    bus.req_op[idx*2 +: 2]    = op;
    bus.req_a[idx*32 +: 32]   = a;
    bus.req_b[idx*32 +: 32]   = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [1:0]  exp_rdy [4];
  logic [1:0]  exp_id  [4];
  logic [31:0] exp_res [4];
  logic [3:0]  exp_flg [4];

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
`ifdef ALU_ARB_FLAGREG_EN
    bus.req_s     = '0;
`endif
    step();
    step();
    chk("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
    chk("rst_rsp_id",     32'(bus.rsp_id),     32'd0);
    chk("rst_rsp_result", bus.rsp_result,      32'd0);
    chk("rst_rsp_flags",  32'(bus.rsp_flags),  32'd0);
    chk("rst_rsp_err",    32'(bus.rsp_err),    32'd0);
    chk("rst_req_ready",  32'(bus.req_ready),  32'd0);
    reset = 1'b0;

    // Single ADD 5+7, one-cycle latency
    set_req(0, 1'b1, 2'b00, 32'd5, 32'd7);
    #1;
    chk("add_req_ready", 32'(bus.req_ready), 32'd1);
    chk("add_alu_srcA",  bus.alu_srcA,       32'd5);
    chk("add_alu_ctrl",  32'(bus.alu_ctrl),  32'd0);
    step();
    chk("add_rsp_valid",  32'(bus.rsp_valid), 32'd1);
    chk("add_rsp_id",     32'(bus.rsp_id),    32'd0);
    chk("add_rsp_result", bus.rsp_result,     32'd12);
    chk("add_rsp_flags",  32'(bus.rsp_flags), 32'd0);
    chk("add_full_ready", 32'(bus.req_ready), 32'd0);
    set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);
    bus.rsp_ready = 1'b1;
    step();
    chk("drain_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Alternation; ptr is 1 after the previous grant to requester 0
    exp_rdy = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_id  = '{2'd1, 2'd0, 2'd1, 2'd0};
    exp_res = '{32'd0, 32'd3, 32'd0, 32'd3};
    exp_flg = '{4'b0110, 4'b0000, 4'b0110, 4'b0000};
    set_req(0, 1'b1, 2'b00, 32'd1, 32'd2);
    set_req(1, 1'b1, 2'b01, 32'd3, 32'd3);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_ready_%0d", i), 32'(bus.req_ready), 32'(exp_rdy[i]));
      step();
      chk($sformatf("rr_id_%0d", i),     32'(bus.rsp_id),    32'(exp_id[i]));
      chk($sformatf("rr_result_%0d", i), bus.rsp_result,     exp_res[i]);
      chk($sformatf("rr_flags_%0d", i),  32'(bus.rsp_flags), 32'(exp_flg[i]));
    end

    // Backpressure: FULL with id0/result 3, both requesters pending
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_ready_%0d", i),  32'(bus.req_ready), 32'd0);
      chk($sformatf("bp_valid_%0d", i),  32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp_id_%0d", i),     32'(bus.rsp_id),    32'd0);
      chk($sformatf("bp_result_%0d", i), bus.rsp_result,     32'd3);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'b10);
    step();
    chk("bp_refill_valid",  32'(bus.rsp_valid), 32'd1);
    chk("bp_refill_id",     32'(bus.rsp_id),    32'd1);
    chk("bp_refill_result", bus.rsp_result,     32'd0);
    chk("bp_refill_flags",  32'(bus.rsp_flags), 32'b0110);
    set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);
    set_req(1, 1'b0, 2'b00, 32'd0, 32'd0);
    step();
    chk("bp_drained", 32'(bus.rsp_valid), 32'd0);

    // Illegal op on requester 0 (ptr is 0 here)
    set_req(0, 1'b1, 2'b11, 32'd1, 32'd2);
    #1;
    chk("ill_alu_ctrl",  32'(bus.alu_ctrl),  32'd0);
    chk("ill_req_ready", 32'(bus.req_ready), 32'd1);
    step();
    chk("ill_rsp_err",    32'(bus.rsp_err),   32'd1);
    chk("ill_rsp_result", bus.rsp_result,     32'd0);
    chk("ill_rsp_flags",  32'(bus.rsp_flags), 32'd0);
    set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);

    // MOV-B on requester 1, pointer wraps back to 0 afterwards
    set_req(1, 1'b1, 2'b10, 32'd9, 32'hFFFF_FFF0);
    #1;
    chk("mov_req_ready", 32'(bus.req_ready), 32'b10);
    step();
    chk("mov_rsp_result", bus.rsp_result,     32'hFFFF_FFF0);
    chk("mov_rsp_flags",  32'(bus.rsp_flags), 32'b1000);
    chk("mov_rsp_err",    32'(bus.rsp_err),   32'd0);
    set_req(1, 1'b0, 2'b00, 32'd0, 32'd0);
    step();

    // Reset mid-transfer: ptr becomes 1 after this grant, then reset returns it to 0
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 2'b00, 32'd2, 32'd2);
    step();
    chk("pre_rst_valid",  32'(bus.rsp_valid), 32'd1);
    chk("pre_rst_result", bus.rsp_result,     32'd4);
    set_req(1, 1'b1, 2'b00, 32'd6, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid",  32'(bus.rsp_valid), 32'd0);
    chk("async_rst_id",     32'(bus.rsp_id),    32'd0);
    chk("async_rst_result", bus.rsp_result,     32'd0);
    chk("async_rst_flags",  32'(bus.rsp_flags), 32'd0);
    chk("async_rst_err",    32'(bus.rsp_err),   32'd0);
    step();
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    step();
    chk("post_rst_id",     32'(bus.rsp_id), 32'd0);
    chk("post_rst_result", bus.rsp_result,  32'd4);
    set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);
    set_req(1, 1'b0, 2'b00, 32'd0, 32'd0);
    step();

`ifdef ALU_ARB_FLAGREG_EN
    // ptr is 1: SUB on requester 1 sets flags, then ADD on requester 0 without set-flags
    chk("nzcv_init", 32'(bus.nzcv), 32'd0);
    set_req(1, 1'b1, 2'b01, 32'h8000_0000, 32'd1);
    bus.req_s = 2'b10;
    step();
    chk("nzcv_sub", 32'(bus.nzcv), 32'b0011);
    set_req(1, 1'b0, 2'b00, 32'd0, 32'd0);
    set_req(0, 1'b1, 2'b00, 32'd0, 32'd0);
    bus.req_s = 2'b00;
    step();
    chk("nzcv_hold_rsp_flags", 32'(bus.rsp_flags), 32'b0100);
    chk("nzcv_hold", 32'(bus.nzcv), 32'b0011);
    set_req(0, 1'b0, 2'b00, 32'd0, 32'd0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
